// File: rtl/sccomp_dataflow_pkg.sv
// sccomp_dataflow_pkg: opcode/funct constants, ALU-op and FSM-state enums, ALU-op decode
package sccomp_dataflow_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08, F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b;
  typedef enum logic [3:0] {A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_NOR, A_SLT, A_SLTU, A_SLL, A_SRL, A_SRA, A_LUI} alu_e;
  typedef enum logic [1:0] {S_IF, S_EX, S_MEM, S_WB} state_e;
  function automatic alu_e alu_sel(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_R)
      case (fn)
        F_SUBU: return A_SUB;
        F_AND:  return A_AND;
        F_OR:   return A_OR;
        F_XOR:  return A_XOR;
        F_NOR:  return A_NOR;
        F_SLT:  return A_SLT;
        F_SLTU: return A_SLTU;
        F_SLL:  return A_SLL;
        F_SRL:  return A_SRL;
        F_SRA:  return A_SRA;
        default: return A_ADD;
      endcase
    case (op)
      OP_ANDI:  return A_AND;
      OP_ORI:   return A_OR;
      OP_XORI:  return A_XOR;
      OP_LUI:   return A_LUI;
      OP_SLTI:  return A_SLT;
      OP_SLTIU: return A_SLTU;
      default:  return A_ADD;
    endcase
  endfunction
endpackage

// File: rtl/sccomp_dataflow_cpu.sv
// sccomp_dataflow_cpu: multi-cycle MIPS-subset core (IF/EX/MEM/WB); inst in, pc out, word data port to RAM
module sccomp_dataflow_cpu
  import sccomp_dataflow_pkg::*;
#(
  parameter int          ADDR_BITS = 13,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [31:0]          inst,
  input  logic [31:0]          dmem_rdata,
  output logic [31:0]          pc,
  output logic [ADDR_BITS-3:0] dmem_addr,
  output logic [31:0]          dmem_wdata,
  output logic                 dmem_we
);
  state_e state, state_n;
  logic [31:0] ir, res, alu_y, rs_v, rt_v, imm_x, b, pc4, npc, wd;
  logic [5:0] op, fn;
  logic [4:0] wa;
  logic r_alu, i_alu, is_lw, is_sw, is_jal, is_jr, take, rf_we, pc_ld;
  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign r_alu = op == OP_R && fn inside {F_SLL, F_SRL, F_SRA, F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU};
  assign i_alu = op inside {OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
  assign is_lw = op == OP_LW;
  assign is_sw = op == OP_SW;
  assign is_jal = op == OP_JAL;
  assign is_jr = op == OP_R && fn == F_JR;
  assign imm_x = op inside {OP_ANDI, OP_ORI, OP_XORI} ? {16'b0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
  assign b = op == OP_R ? rt_v : imm_x;
  assign pc4 = pc + 32'd4;
  assign take = (op == OP_BEQ && rs_v == rt_v) || (op == OP_BNE && rs_v != rt_v);
  assign npc = take ? pc4 + {imm_x[29:0], 2'b00} : (op == OP_J || is_jal) ? {pc4[31:28], ir[25:0], 2'b00} : is_jr ? rs_v : pc4;
  assign rf_we = state == S_WB || (state == S_EX && is_jal);
  assign wa = is_jal ? 5'd31 : op == OP_R ? ir[15:11] : ir[20:16];
  assign wd = is_jal ? pc4 : is_lw ? dmem_rdata : res;
  assign dmem_addr = res[ADDR_BITS-1:2];
  assign dmem_wdata = rt_v;
  assign dmem_we = state == S_MEM && is_sw;
  sccomp_dataflow_regfile cpu_ref (.clk_in, .reset, .we(rf_we), .ra1(ir[25:21]), .ra2(ir[20:16]), .wa, .wd, .rd1(rs_v), .rd2(rt_v));
  always_comb begin
    alu_y = '0;
    case (alu_sel(op, fn))
      A_ADD:  alu_y = rs_v + b;
      A_SUB:  alu_y = rs_v - b;
      A_AND:  alu_y = rs_v & b;
      A_OR:   alu_y = rs_v | b;
      A_XOR:  alu_y = rs_v ^ b;
      A_NOR:  alu_y = ~(rs_v | b);
      A_SLT:  alu_y = {31'b0, $signed(rs_v) < $signed(b)};
      A_SLTU: alu_y = {31'b0, rs_v < b};
      A_SLL:  alu_y = rt_v << ir[10:6];
      A_SRL:  alu_y = rt_v >> ir[10:6];
      A_SRA:  alu_y = $signed(rt_v) >>> ir[10:6];
      A_LUI:  alu_y = {ir[15:0], 16'b0};
      default: alu_y = '0;
    endcase
  end
  always_comb begin
    state_n = S_IF;
    pc_ld = 1'b0;
    state_n = state == S_IF ? S_EX :
              state == S_EX ? ((r_alu || i_alu) ? S_WB : (is_lw || is_sw) ? S_MEM : S_IF) :
              state == S_MEM ? (is_lw ? S_WB : S_IF) : S_IF;
    pc_ld = state == S_EX ? !(r_alu || i_alu || is_lw || is_sw) : state == S_MEM ? is_sw : state == S_WB;
  end
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      state <= S_IF;
      pc <= RESET_PC;
      ir <= '0;
      res <= '0;
    end else begin
      state <= state_n;
      if (state == S_IF) ir <= inst;
      if (state == S_EX) res <= alu_y;
      if (pc_ld) pc <= npc;
    end
endmodule

// File: rtl/sccomp_dataflow_mem8.sv
// sccomp_dataflow_mem8: 8-bit RAM lane; async reads at ia (inst) and da (data), sync write at da
module sccomp_dataflow_mem8 #(
  parameter int AW = 11
) (
  input  logic          clk_in,
  input  logic          we,
  input  logic [AW-1:0] ia,
  input  logic [AW-1:0] da,
  input  logic [7:0]    wd,
  output logic [7:0]    id,
  output logic [7:0]    dd
);
  logic [7:0] mem [0:2**AW-1];
  assign id = mem[ia];
  assign dd = mem[da];
  always_ff @(posedge clk_in)
    if (we) mem[da] <= wd;
endmodule

// File: rtl/sccomp_dataflow_ram.sv
// sccomp_dataflow_ram: unified word RAM of four byte lanes; inst read at ia, data read/write at da
module sccomp_dataflow_ram #(
  parameter int AW = 11
) (
  input  logic          clk_in,
  input  logic          we,
  input  logic [AW-1:0] ia,
  input  logic [AW-1:0] da,
  input  logic [31:0]   wd,
  output logic [31:0]   id,
  output logic [31:0]   dd
);
  sccomp_dataflow_mem8 #(.AW(AW)) mem8_inst0 (.clk_in, .we, .ia, .da, .wd(wd[7:0]),   .id(id[7:0]),   .dd(dd[7:0]));
  sccomp_dataflow_mem8 #(.AW(AW)) mem8_inst1 (.clk_in, .we, .ia, .da, .wd(wd[15:8]),  .id(id[15:8]),  .dd(dd[15:8]));
  sccomp_dataflow_mem8 #(.AW(AW)) mem8_inst2 (.clk_in, .we, .ia, .da, .wd(wd[23:16]), .id(id[23:16]), .dd(dd[23:16]));
  sccomp_dataflow_mem8 #(.AW(AW)) mem8_inst3 (.clk_in, .we, .ia, .da, .wd(wd[31:24]), .id(id[31:24]), .dd(dd[31:24]));
endmodule

// File: rtl/sccomp_dataflow_regfile.sv
// sccomp_dataflow_regfile: 32x32 register file, two async reads, one sync write, $0 hardwired to zero, async clear
module sccomp_dataflow_regfile (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] array_reg [0:31];
  assign rd1 = ra1 == 5'd0 ? '0 : array_reg[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : array_reg[ra2];
  always_ff @(posedge clk_in or posedge reset)
    if (reset) for (int i = 0; i < 32; i++) array_reg[i] <= '0;
    else if (we && wa != 5'd0) array_reg[wa] <= wd;
endmodule

// File: rtl/sccomp_dataflow.sv
// sccomp_dataflow: multi-cycle MIPS-subset CPU + unified byte-lane RAM; clk_in/reset in, pc and inst-at-pc out
module sccomp_dataflow #(
  parameter int          ADDR_BITS = 13,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk_in,
  input  logic        reset,
  output logic [31:0] inst,
  output logic [31:0] pc
);
  logic [31:0] dmem_rdata, dmem_wdata;
  logic [ADDR_BITS-3:0] dmem_addr;
  logic dmem_we;
  sccomp_dataflow_cpu #(.ADDR_BITS(ADDR_BITS), .RESET_PC(RESET_PC)) sccpu (
    .clk_in, .reset, .inst, .dmem_rdata, .pc, .dmem_addr, .dmem_wdata, .dmem_we
  );
  sccomp_dataflow_ram #(.AW(ADDR_BITS - 2)) ram_inst (
    .clk_in, .we(dmem_we), .ia(pc[ADDR_BITS-1:2]), .da(dmem_addr), .wd(dmem_wdata), .id(inst), .dd(dmem_rdata)
  );
endmodule

// File: tb/tb_sccomp_dataflow.sv
// tb_sccomp_dataflow: directed program run with hand-computed pc sequence, cycle counts and register values
module tb_sccomp_dataflow;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic [31:0] inst, pc;
  int nchk = 0;
  int nerr = 0;
  sccomp_dataflow dut (.clk_in(clk_in), .reset(reset), .inst(inst), .pc(pc));
  always #5 clk_in = ~clk_in;
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction
  function automatic logic [31:0] rg(input int i);
    return dut.sccpu.cpu_ref.array_reg[i];
  endfunction
  function automatic logic [31:0] regs_or();
    logic [31:0] a = '0;
    for (int i = 0; i < 32; i++) a |= dut.sccpu.cpu_ref.array_reg[i];
    return a;
  endfunction
  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    dut.ram_inst.mem8_inst0.mem[addr[12:2]] = w[7:0];
    dut.ram_inst.mem8_inst1.mem[addr[12:2]] = w[15:8];
    dut.ram_inst.mem8_inst2.mem[addr[12:2]] = w[23:16];
    dut.ram_inst.mem8_inst3.mem[addr[12:2]] = w[31:24];
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_inst(input string tag, input int cyc, input logic [31:0] npc);
    logic [31:0] p0;
    int n;
    p0 = pc;
    n = 0;
    do begin
      @(posedge clk_in);
      #1;
      n++;
    end while (pc == p0 && n < 12);
    check({tag, "_cycles"}, 32'(n), 32'(cyc));
    check({tag, "_pc"}, pc, npc);
  endtask
  initial begin
    logic [31:0] w0;
    for (int i = 0; i < 2048; i++) put(32'(i) << 2, 32'h0);
    w0 = enc_i(6'h09, 5'd0, 5'd1, 16'd5);
    put(32'h00, w0);
    put(32'h04, enc_i(6'h09, 5'd0, 5'd2, 16'hfffd));
    put(32'h08, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21));
    put(32'h0c, enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h23));
    put(32'h10, enc_r(5'd2, 5'd1, 5'd5, 5'd0, 6'h2a));
    put(32'h14, enc_r(5'd2, 5'd1, 5'd6, 5'd0, 6'h2b));
    put(32'h18, enc_i(6'h0f, 5'd0, 5'd1, 16'h1234));
    put(32'h1c, enc_i(6'h0d, 5'd1, 5'd1, 16'h5678));
    put(32'h20, enc_i(6'h0f, 5'd0, 5'd1, 16'h8000));
    put(32'h24, enc_r(5'd0, 5'd1, 5'd2, 5'd4, 6'h03));
    put(32'h28, enc_i(6'h09, 5'd0, 5'd1, 16'h0100));
    put(32'h2c, enc_i(6'h09, 5'd0, 5'd2, 16'h007f));
    put(32'h30, enc_i(6'h2b, 5'd1, 5'd2, 16'd4));
    put(32'h34, enc_i(6'h23, 5'd1, 5'd3, 16'd4));
    put(32'h38, enc_j(6'h02, 26'h20));
    put(32'h3c, enc_i(6'h09, 5'd0, 5'd7, 16'd1));
    put(32'h40, enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
    put(32'h80, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
    put(32'h84, enc_i(6'h09, 5'd0, 5'd7, 16'd1));
    put(32'h88, enc_i(6'h09, 5'd0, 5'd7, 16'd1));
    put(32'h8c, enc_i(6'h04, 5'd1, 5'd2, 16'd5));
    put(32'h90, enc_i(6'h05, 5'd1, 5'd2, 16'd1));
    put(32'h94, enc_i(6'h09, 5'd0, 5'd7, 16'd1));
    put(32'h98, enc_j(6'h03, 26'h10));
    put(32'h9c, enc_i(6'h09, 5'd0, 5'd0, 16'd7));
    put(32'ha0, 32'hfc00_0000);
    put(32'ha4, enc_i(6'h23, 5'd1, 5'd8, 16'd4));
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, w0);
    check("rst_regs", regs_or(), 32'h0);
    #5 reset = 1'b0;
    run_inst("addiu1", 3, 32'h04);
    check("r1_5", rg(1), 32'd5);
    run_inst("addiu2", 3, 32'h08);
    check("r2_m3", rg(2), 32'hffff_fffd);
    run_inst("addu", 3, 32'h0c);
    check("addu_r3", rg(3), 32'd2);
    run_inst("subu", 3, 32'h10);
    check("subu_r4", rg(4), 32'hffff_fff8);
    run_inst("slt", 3, 32'h14);
    check("slt_r5", rg(5), 32'd1);
    run_inst("sltu", 3, 32'h18);
    check("sltu_r6", rg(6), 32'd0);
    run_inst("lui", 3, 32'h1c);
    check("lui_r1", rg(1), 32'h1234_0000);
    run_inst("ori", 3, 32'h20);
    check("ori_r1", rg(1), 32'h1234_5678);
    run_inst("lui8", 3, 32'h24);
    run_inst("sra", 3, 32'h28);
    check("sra_r2", rg(2), 32'hf800_0000);
    run_inst("base", 3, 32'h2c);
    run_inst("data", 3, 32'h30);
    run_inst("sw", 3, 32'h34);
    check("sw_lanes", {dut.ram_inst.mem8_inst3.mem[11'h41], dut.ram_inst.mem8_inst2.mem[11'h41],
                       dut.ram_inst.mem8_inst1.mem[11'h41], dut.ram_inst.mem8_inst0.mem[11'h41]}, 32'h0000_007f);
    run_inst("lw", 4, 32'h38);
    check("lw_r3", rg(3), 32'h7f);
    run_inst("j", 2, 32'h80);
    run_inst("beq_t", 2, 32'h8c);
    run_inst("beq_nt", 2, 32'h90);
    run_inst("bne_t", 2, 32'h98);
    run_inst("jal", 2, 32'h40);
    check("jal_r31", rg(31), 32'h9c);
    run_inst("jr", 2, 32'h9c);
    run_inst("addiu_r0", 3, 32'ha0);
    check("r0_zero", rg(0), 32'h0);
    run_inst("undef", 2, 32'ha4);
    check("slot_r7", rg(7), 32'h0);
    check("undef_r1", rg(1), 32'h100);
    check("undef_r3", rg(3), 32'h7f);
    check("undef_r31", rg(31), 32'h9c);
    @(posedge clk_in);
    #1;
    @(posedge clk_in);
    #1;
    check("lw_mem_pc", pc, 32'ha4);
    reset = 1'b1;
    #1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_regs", regs_or(), 32'h0);
    check("midrst_inst", inst, w0);
    #4 reset = 1'b0;
    run_inst("post_rst", 3, 32'h04);
    check("post_r1", rg(1), 32'd5);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/sccomp_dataflow.md
Name: sccomp_dataflow

Overview:
- Top-level SoC: a multi-cycle MIPS-subset CPU plus one unified byte-lane RAM that holds both instructions and data.
- Exposes the PC and instruction of the in-flight instruction so a bench can trace execution and dump the register file at each instruction boundary.
- Sits at the top of the design; the bench preloads the RAM lanes hierarchically.

Parameters:
- ADDR_BITS, 13, byte-address bits decoded by RAM (8 KiB); upper address bits ignored (aliasing).
- RESET_PC, 32'h0000_0000, PC after reset.

Ports:
- clk_in  input  1  system clock, rising edge active.
- reset  input  1  asynchronous, active-high reset.
- inst  output  32  instruction word at address pc.
- pc  output  32  address of the instruction currently executing.

Behaviour:
- Hierarchy names are mandatory:
  - CPU instance `sccpu`, containing regfile instance `cpu_ref` with array `array_reg[0:31]` (32-bit).
  - RAM instance `ram_inst`, containing byte lanes `mem8_inst0..3`, each with array `mem[0:2^(ADDR_BITS-2)-1]` (8-bit).
  - Lane k holds byte k of each word (bits 8k+7:8k; lane 3 = bits 31:24).
- RAM:
  - Two asynchronous read ports: instruction at pc[ADDR_BITS-1:2]; data at ALU address.
  - One synchronous write port, on clk_in rising edge.
  - Not cleared by reset.
- inst is combinational from RAM at pc, so inst always matches pc.
- Reset (async): pc = RESET_PC, FSM = IF, all 32 registers = 0. Memory untouched.
- FSM states: IF, EX, MEM, WB.
  - IF: latch IR = inst.
  - EX: ALU/compare/target computation.
  - MEM: data access.
  - WB: register write.
- Per-instruction cycles (pc updates on the edge leaving the last state):
  - R-ALU and I-ALU: IF, EX, WB (3 cycles).
  - lw: IF, EX, MEM, WB (4 cycles).
  - sw: IF, EX, MEM (3 cycles); write occurs in MEM.
  - beq, bne, j, jr: IF, EX (2 cycles).
  - jal: IF, EX (2 cycles); $31 = pc+4 written in EX.
- pc changes only at instruction boundaries, after all architectural effects of the previous instruction are committed.
- Supported instructions:
  - R-type: addu, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addiu, andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne.
  - J-type: j, jal.
- Immediates: andi/ori/xori zero-extend; all other immediates sign-extend.
- Arithmetic:
  - No overflow traps.
  - Shifts use shamt.
  - slt is signed; sltu is unsigned.
  - lui loads imm<<16.
- Targets:
  - Branch: pc+4 + (sext(imm)<<2).
  - j/jal: {pc+4[31:28], idx, 2'b00}.
  - No delay slots.
- lw/sw: word only, address = rs + sext(imm); low two address bits ignored.
- Register $0 always reads 0; writes to it are discarded.
- Undefined opcode: treated as NOP (IF, EX; pc += 4).
- pc wraps modulo 2^32.
- Reset mid-instruction aborts it. Any sw already clocked stays in memory.

Decomposition:
- Shared package holds:
  - opcode and funct constants;
  - ALU-op enum;
  - FSM state enum (IF, EX, MEM, WB).
- One natural sub-module: mem8, an 8-bit-wide lane with two async reads and one sync write, instantiated four times in the RAM.
- Regfile and CPU datapath may be written as plain sub-blocks under the mandated instance names.

Test Plan:
- Reset:
  - Stimulus: assert reset high 6 ns, release.
  - Required: pc=0, inst=mem word 0, all array_reg=0; first pc change to 4 only after that instruction completes.
- ALU:
  - Stimulus: addiu $1,$0,5; addiu $2,$0,-3; addu $3,$1,$2; subu $4,$2,$1; slt $5,$2,$1; sltu $6,$2,$1.
  - Required: $3=2, $4=0xFFFFFFF8, $5=1, $6=0.
- Logic/shift:
  - Stimulus: lui $1,0x1234; ori $1,$1,0x5678; sra $2,$1,4 with $1=0x80000000.
  - Required: $1=0x12345678 after ori; $2=0xF8000000.
- Memory:
  - Stimulus: addiu $1,$0,0x100; addiu $2,$0,0x7F; sw $2,4($1); lw $3,4($1).
  - Required: $3=0x7F; lanes at index 0x41 = 7F,00,00,00.
- Control:
  - Stimulus: beq taken, beq not taken, bne taken, j, jal to 0x40, jr $31.
  - Required: each pc sequence exact; $31=pc_of_jal+4; no delay-slot execution.
- Boundary:
  - Stimulus: addiu $0,$0,7.
  - Required: $0 stays 0.
  - Stimulus: undefined opcode.
  - Required: pc+4 after 2 cycles, no register change.
  - Stimulus: reset asserted during lw MEM.
  - Required: pc=0, regs=0 immediately.
